// File: rtl/cap_ctrl_pkg.sv
// cap_ctrl_pkg: shared definitions for the CAP2019 multi-cycle controller.
// Holds the FSM state encoding, opcode constants, ALU function codes, the
// PC_Src / Wb_Sel selector codes and the opcode-to-class decode helpers.
package cap_ctrl_pkg;

  // State encoding is visible on the State debug port, so values are fixed.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_JAL,
    CLS_IMM,
    CLS_LOAD,
    CLS_BRANCH,
    CLS_STORE,
    CLS_HALT
  } op_class_e;

  // Opcodes (4-bit map)
  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_JAL    = 4'b0001;
  localparam logic [3:0] OP_R2     = 4'b0010;
  localparam logic [3:0] OP_R3     = 4'b0011;
  localparam logic [3:0] OP_R4     = 4'b0100;
  localparam logic [3:0] OP_R5     = 4'b0101;
  localparam logic [3:0] OP_R6     = 4'b0110;
  localparam logic [3:0] OP_IMM7   = 4'b0111;
  localparam logic [3:0] OP_LOAD   = 4'b1000;
  localparam logic [3:0] OP_BRANCH = 4'b1001;
  localparam logic [3:0] OP_STORE  = 4'b1010;
  localparam logic [3:0] OP_RB     = 4'b1011;
  localparam logic [3:0] OP_RC     = 4'b1100;
  localparam logic [3:0] OP_RD     = 4'b1101;
  localparam logic [3:0] OP_IMME   = 4'b1110;
  localparam logic [3:0] OP_HALT   = 4'b1111;

  // ALU function codes
  localparam logic [2:0] ALU_F0  = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_F2  = 3'd2;
  localparam logic [2:0] ALU_F3  = 3'd3;
  localparam logic [2:0] ALU_F4  = 3'd4;
  localparam logic [2:0] ALU_F5  = 3'd5;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_F7  = 3'd7;

  // PC source and write-back source selectors
  localparam logic [1:0] PC_SRC_PLUS1  = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] WB_SEL_ALU    = 2'd0;
  localparam logic [1:0] WB_SEL_MEM    = 2'd1;
  localparam logic [1:0] WB_SEL_LINK   = 2'd2;

  function automatic op_class_e decode_class(input logic [3:0] op);
    case (op)
      OP_JAL:           return CLS_JAL;
      OP_IMM7, OP_IMME: return CLS_IMM;
      OP_LOAD:          return CLS_LOAD;
      OP_BRANCH:        return CLS_BRANCH;
      OP_STORE:         return CLS_STORE;
      OP_HALT:          return CLS_HALT;
      default:          return CLS_ALU;
    endcase
  endfunction

  // Branches compare by subtraction; anything without its own code adds.
  function automatic logic [2:0] alu_op_of(input logic [3:0] op);
    case (op)
      OP_R2:     return ALU_F2;
      OP_R4:     return ALU_SUB;
      OP_R5:     return ALU_F3;
      OP_R6:     return ALU_F5;
      OP_RB:     return ALU_F0;
      OP_RC:     return ALU_F4;
      OP_RD:     return ALU_F7;
      OP_BRANCH: return ALU_SUB;
      default:   return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive memory wait cycles and flags a timeout.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       zero the counter (new request phase begins next cycle)
//   busy        a memory request is outstanding this cycle
//   ready       memory completes the request this cycle
//   expired     this cycle would be wait number TIMEOUT_CYCLES+1, i.e. the
//               budget of TIMEOUT_CYCLES wait cycles is already spent
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic busy,
  input  logic ready,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = busy && !ready && (cnt_q == W'(TIMEOUT_CYCLES));

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (busy && !ready && !expired) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: sequencing FSM for the multi-cycle CAP2019 datapath.
// One phase per state (FETCH, DECODE, EXEC, MEM, WB), variable-latency memory
// handshake, sticky halt on HALT or memory timeout.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   Op_Code, Zero         IR opcode field, ALU zero flag
//   Mem_Ready             memory completes the request held this cycle
//   Mem_Req/We/Addr_Sel   memory port control
//   IR_Write, PC_Write, PC_Src, Reg_Write, Wb_Sel, ALU_Src_B, ALU_Op
//                         datapath enables and selects
//   Halted, Mem_Fault     sticky status
//   State, Retired        debug state and retired-instruction count
module multi_cycle_controller
  import cap_ctrl_pkg::*;
#(
  parameter int OPCODE_W       = 4,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] Op_Code,
  input  logic                Zero,
  input  logic                Mem_Ready,
  output logic                Mem_Req,
  output logic                Mem_We,
  output logic                Mem_Addr_Sel,
  output logic                IR_Write,
  output logic                PC_Write,
  output logic [1:0]          PC_Src,
  output logic                Reg_Write,
  output logic [1:0]          Wb_Sel,
  output logic                ALU_Src_B,
  output logic [2:0]          ALU_Op,
  output logic                Halted,
  output logic                Mem_Fault,
  output logic [2:0]          State,
  output logic [CNT_W-1:0]    Retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             mem_fault_q, mem_fault_d;
  logic             retire;
  logic             timer_clear;
  logic             expired;
  op_class_e        cls;

  assign cls = decode_class(Op_Code[3:0]);

  // Next state, retirement and fault detection
  always_comb begin
    state_d     = state_q;
    mem_fault_d = mem_fault_q;
    retire      = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (Mem_Ready) begin
          state_d = ST_DECODE;
        end else if (expired) begin
          state_d     = ST_HALTED;
          mem_fault_d = 1'b1;
        end
      end
      ST_DECODE: begin
        if (cls == CLS_HALT) begin
          state_d = ST_HALTED;
          retire  = 1'b1;
        end else if (cls == CLS_JAL) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls == CLS_BRANCH) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end else if (cls == CLS_LOAD || cls == CLS_STORE) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (Mem_Ready) begin
          if (cls == CLS_STORE) begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end else if (expired) begin
          state_d     = ST_HALTED;
          mem_fault_d = 1'b1;
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_FETCH;
    endcase
    retired_d = retired_q + (retire ? CNT_W'(1) : CNT_W'(0));
  end

  // The wait count restarts whenever a new request phase is entered.
  assign timer_clear = (state_d != state_q) &&
                       (state_d == ST_FETCH || state_d == ST_MEM);

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .busy   (Mem_Req),
    .ready  (Mem_Ready),
    .expired(expired)
  );

  // Control decode from the registered state. FETCH completion is
  // qualified by Mem_Ready so IR/PC load in the same cycle the data arrives.
  always_comb begin
    Mem_Req      = 1'b0;
    Mem_We       = 1'b0;
    Mem_Addr_Sel = 1'b0;
    IR_Write     = 1'b0;
    PC_Write     = 1'b0;
    PC_Src       = PC_SRC_PLUS1;
    Reg_Write    = 1'b0;
    Wb_Sel       = WB_SEL_ALU;
    ALU_Src_B    = 1'b0;
    ALU_Op       = 3'd0;
    Halted       = 1'b0;
    // NOTE: outputs are forced low while rst_n is held so the memory sees the request dropped at once, not just at the next edge.
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          Mem_Req = 1'b1;
          if (Mem_Ready) begin
            IR_Write = 1'b1;
            PC_Write = 1'b1;
          end
        end
        ST_EXEC: begin
          ALU_Op    = alu_op_of(Op_Code[3:0]);
          ALU_Src_B = (cls == CLS_IMM) || (cls == CLS_LOAD) || (cls == CLS_STORE);
          if (cls == CLS_BRANCH) begin
            PC_Write = Zero;
            PC_Src   = PC_SRC_BRANCH;
          end
        end
        ST_MEM: begin
          Mem_Req      = 1'b1;
          Mem_Addr_Sel = 1'b1;
          Mem_We       = (cls == CLS_STORE);
        end
        ST_WB: begin
          Reg_Write = 1'b1;
          if (cls == CLS_LOAD) begin
            Wb_Sel = WB_SEL_MEM;
          end else if (cls == CLS_JAL) begin
            Wb_Sel   = WB_SEL_LINK;
            PC_Write = 1'b1;
            PC_Src   = PC_SRC_JUMP;
          end
        end
        ST_HALTED: Halted = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      retired_q   <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      retired_q   <= retired_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  assign State     = state_q;
  assign Retired   = retired_q;
  assign Mem_Fault = mem_fault_q;

endmodule
